// File: rtl/rv32i_pkg.sv
// rv32i_pkg
// Shared definitions for the RV32I core pipeline:
//   - fixed datapath / opcode / register-index widths
//   - ALU operation codes driven on the ALU Operation bus
//   - a_sel_t : SrcA source selector encoding
//   - id_ex_t : packed contents of the ID/EX pipeline register
package rv32i_pkg;

    localparam int XLEN     = 32;
    localparam int ALU_OP_W = 4;
    localparam int REG_W    = 5;

    localparam logic [ALU_OP_W-1:0] ALU_AND = 4'b0000;
    localparam logic [ALU_OP_W-1:0] ALU_OR  = 4'b0001;
    localparam logic [ALU_OP_W-1:0] ALU_ADD = 4'b0010;
    localparam logic [ALU_OP_W-1:0] ALU_XOR = 4'b0011;
    localparam logic [ALU_OP_W-1:0] ALU_SUB = 4'b0110;
    localparam logic [ALU_OP_W-1:0] ALU_EQ  = 4'b1000;

    typedef enum logic [1:0] {
        A_RS1  = 2'd0,
        A_PC   = 2'd1,
        A_ZERO = 2'd2
    } a_sel_t;

    // a_sel is kept as raw bits so the unused encoding 3 survives
    // the register and is decoded as zero downstream.
    typedef struct packed {
        logic                valid;
        logic                mem_read;
        logic                mem_write;
        logic                reg_write;
        logic [REG_W-1:0]    rd;
        logic [REG_W-1:0]    rs1_addr;
        logic [REG_W-1:0]    rs2_addr;
        logic [XLEN-1:0]     rs1_data;
        logic [XLEN-1:0]     rs2_data;
        logic [XLEN-1:0]     imm;
        logic [XLEN-1:0]     pc;
        logic [ALU_OP_W-1:0] alu_op;
        logic [1:0]          a_sel;
        logic                b_imm;
    } id_ex_t;

endpackage

// File: rtl/operand_forward.sv
// operand_forward
// Combinational forwarding mux for one source operand.
// Ports:
//   idx, data                       stored register index and register-file data
//   exmem_rd/_reg_write/_result     EX/MEM writeback candidate (highest priority)
//   memwb_rd/_reg_write/_result     MEM/WB writeback candidate
//   fwd                             resolved operand value
// Register x0 is hard-wired to zero and is never forwarded.
module operand_forward
    import rv32i_pkg::*;
#(
    parameter int DATA_WIDTH = XLEN,
    parameter int REG_ADDR_W = REG_W
) (
    input  logic [REG_ADDR_W-1:0] idx,
    input  logic [DATA_WIDTH-1:0] data,
    input  logic [REG_ADDR_W-1:0] exmem_rd,
    input  logic                  exmem_reg_write,
    input  logic [DATA_WIDTH-1:0] exmem_result,
    input  logic [REG_ADDR_W-1:0] memwb_rd,
    input  logic                  memwb_reg_write,
    input  logic [DATA_WIDTH-1:0] memwb_result,
    output logic [DATA_WIDTH-1:0] fwd
);

    logic exmem_hit;
    logic memwb_hit;

    assign exmem_hit = exmem_reg_write && (exmem_rd != '0) && (exmem_rd == idx);
    assign memwb_hit = memwb_reg_write && (memwb_rd != '0) && (memwb_rd == idx);

    always_comb begin
        fwd = data;
        if (exmem_hit) begin
            fwd = exmem_result;
        end else if (memwb_hit) begin
            fwd = memwb_result;
        end
    end

endmodule

// File: rtl/id_ex_stage.sv
// id_ex_stage
// ID/EX pipeline register feeding the ALU, with operand forwarding and
// load-use hazard detection.
// Ports:
//   clk, reset (sync, active-low)
//   valid_in, id_*                  decoded instruction from the ID stage
//   stall                           downstream stall: hold register contents
//   flush                           squash the instruction entering EX
//   exmem_*, memwb_*                forwarding sources from later stages
//   SrcA, SrcB, Operation           ALU operands and operation
//   store_data                      forwarded rs2 for stores
//   ex_rd, ex_valid, ex_mem_read,
//   ex_mem_write, ex_reg_write      registered destination and control
//   hazard_stall                    freeze PC and IF/ID this cycle
module id_ex_stage
    import rv32i_pkg::*;
#(
    parameter int DATA_WIDTH    = XLEN,
    parameter int OPCODE_LENGTH = ALU_OP_W,
    parameter int REG_ADDR_W    = REG_W
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     valid_in,
    input  logic [REG_ADDR_W-1:0]    id_rs1_addr,
    input  logic [REG_ADDR_W-1:0]    id_rs2_addr,
    input  logic [REG_ADDR_W-1:0]    id_rd_addr,
    input  logic [DATA_WIDTH-1:0]    id_rs1_data,
    input  logic [DATA_WIDTH-1:0]    id_rs2_data,
    input  logic [DATA_WIDTH-1:0]    id_imm,
    input  logic [DATA_WIDTH-1:0]    id_pc,
    input  logic [OPCODE_LENGTH-1:0] id_alu_op,
    input  logic [1:0]               id_a_sel,
    input  logic                     id_b_imm,
    input  logic                     id_mem_read,
    input  logic                     id_mem_write,
    input  logic                     id_reg_write,
    input  logic                     stall,
    input  logic                     flush,
    input  logic [REG_ADDR_W-1:0]    exmem_rd,
    input  logic [REG_ADDR_W-1:0]    memwb_rd,
    input  logic                     exmem_reg_write,
    input  logic                     memwb_reg_write,
    input  logic [DATA_WIDTH-1:0]    exmem_result,
    input  logic [DATA_WIDTH-1:0]    memwb_result,
    output logic [DATA_WIDTH-1:0]    SrcA,
    output logic [DATA_WIDTH-1:0]    SrcB,
    output logic [OPCODE_LENGTH-1:0] Operation,
    output logic [DATA_WIDTH-1:0]    store_data,
    output logic [REG_ADDR_W-1:0]    ex_rd,
    output logic                     ex_valid,
    output logic                     ex_mem_read,
    output logic                     ex_mem_write,
    output logic                     ex_reg_write,
    output logic                     hazard_stall
);

    id_ex_t ex_reg;
    id_ex_t ex_next;
    logic   load_bubble;

    logic [DATA_WIDTH-1:0] rs1_fwd;
    logic [DATA_WIDTH-1:0] rs2_fwd;

    // Capture of the decoded instruction.
    always_comb begin
        ex_next           = '0;
        ex_next.valid     = 1'b1;
        ex_next.mem_read  = id_mem_read;
        ex_next.mem_write = id_mem_write;
        ex_next.reg_write = id_reg_write;
        ex_next.rd        = id_rd_addr;
        ex_next.rs1_addr  = id_rs1_addr;
        ex_next.rs2_addr  = id_rs2_addr;
        ex_next.rs1_data  = id_rs1_data;
        ex_next.rs2_data  = id_rs2_data;
        ex_next.imm       = id_imm;
        ex_next.pc        = id_pc;
        ex_next.alu_op    = id_alu_op;
        ex_next.a_sel     = id_a_sel;
        ex_next.b_imm     = id_b_imm;
    end

    // A load in EX whose destination is read by the instruction in ID
    // cannot be forwarded in time. rs2 is compared even when unused,
    // costing at most one extra bubble. Suppressed under stall because
    // the register does not advance then anyway.
    assign hazard_stall = ex_reg.valid && ex_reg.mem_read && (ex_reg.rd != '0) &&
                          ((ex_reg.rd == id_rs1_addr) || (ex_reg.rd == id_rs2_addr)) &&
                          !stall;

    assign load_bubble = flush || hazard_stall || !valid_in;

    // Priority: reset > stall (hold) > flush / hazard / invalid (bubble) > load.
    always_ff @(posedge clk) begin
        if (!reset) begin
            ex_reg <= '0;
        end else if (stall) begin
            ex_reg <= ex_reg;
        end else if (load_bubble) begin
            ex_reg <= '0;
        end else begin
            ex_reg <= ex_next;
        end
    end

    operand_forward #(
        .DATA_WIDTH (DATA_WIDTH),
        .REG_ADDR_W (REG_ADDR_W)
    ) u_fwd_rs1 (
        .idx             (ex_reg.rs1_addr),
        .data            (ex_reg.rs1_data),
        .exmem_rd        (exmem_rd),
        .exmem_reg_write (exmem_reg_write),
        .exmem_result    (exmem_result),
        .memwb_rd        (memwb_rd),
        .memwb_reg_write (memwb_reg_write),
        .memwb_result    (memwb_result),
        .fwd             (rs1_fwd)
    );

    operand_forward #(
        .DATA_WIDTH (DATA_WIDTH),
        .REG_ADDR_W (REG_ADDR_W)
    ) u_fwd_rs2 (
        .idx             (ex_reg.rs2_addr),
        .data            (ex_reg.rs2_data),
        .exmem_rd        (exmem_rd),
        .exmem_reg_write (exmem_reg_write),
        .exmem_result    (exmem_result),
        .memwb_rd        (memwb_rd),
        .memwb_reg_write (memwb_reg_write),
        .memwb_result    (memwb_result),
        .fwd             (rs2_fwd)
    );

    // Encoding 3 is not a defined source and falls through to zero.
    always_comb begin
        SrcA = '0;
        case (ex_reg.a_sel)
            A_RS1:   SrcA = rs1_fwd;
            A_PC:    SrcA = ex_reg.pc;
            default: SrcA = '0;
        endcase
    end

    assign SrcB         = ex_reg.b_imm ? ex_reg.imm : rs2_fwd;
    assign store_data   = rs2_fwd;
    assign Operation    = ex_reg.alu_op;
    assign ex_rd        = ex_reg.rd;
    assign ex_valid     = ex_reg.valid;
    assign ex_mem_read  = ex_reg.mem_read;
    assign ex_mem_write = ex_reg.mem_write;
    assign ex_reg_write = ex_reg.reg_write;

endmodule

// File: doc/id_ex_stage.md
# id_ex_stage

ID/EX pipeline register for the RV32I core, directly upstream of the ALU. It captures decoded operands and control each cycle and drives the ALU's `SrcA`, `SrcB` and `Operation`. It also resolves EX/MEM and MEM/WB data forwarding on the outputs, and detects load-use hazards. On a hazard it inserts a bubble and stalls fetch/decode.

## Interface
- `DATA_WIDTH`, 32, datapath width
- `OPCODE_LENGTH`, 4, ALU operation code width
- `REG_ADDR_W`, 5, register index width
- `clk`  in  1  single clock; all state on rising edge
- `reset`  in  1  synchronous, active-low
- `valid_in`  in  1  decode holds a real instruction
- `id_rs1_addr`, `id_rs2_addr`, `id_rd_addr`  in  REG_ADDR_W  decoded register indices
- `id_rs1_data`, `id_rs2_data`, `id_imm`, `id_pc`  in  DATA_WIDTH  register-file reads, immediate, PC
- `id_alu_op`  in  OPCODE_LENGTH  ALU operation
- `id_a_sel`  in  2  SrcA source: 0 rs1, 1 PC, 2 zero
- `id_b_imm`  in  1  SrcB = immediate when 1
- `id_mem_read`, `id_mem_write`, `id_reg_write`  in  1  memory/writeback control
- `stall`  in  1  downstream stall; hold contents
- `flush`  in  1  squash the instruction entering EX
- `exmem_rd`, `memwb_rd`  in  REG_ADDR_W  destinations of later stages
- `exmem_reg_write`, `memwb_reg_write`  in  1  later stages write back
- `exmem_result`, `memwb_result`  in  DATA_WIDTH  forwardable values
- `SrcA`, `SrcB`  out  DATA_WIDTH  ALU operands (combinational from register plus forwarding)
- `Operation`  out  OPCODE_LENGTH  registered ALU op
- `store_data`  out  DATA_WIDTH  forwarded rs2 for stores
- `ex_rd`  out  REG_ADDR_W  registered destination
- `ex_valid`, `ex_mem_read`, `ex_mem_write`, `ex_reg_write`  out  1  registered control
- `hazard_stall`  out  1  combinational; freeze PC and IF/ID this cycle

## Operation
- **Register update priority at each edge:** reset > `stall` (hold all) > `flush` (load bubble) > `hazard_stall` (load bubble) > load ID fields.
- **Bubble:** `ex_valid`, `ex_mem_read`, `ex_mem_write` and `ex_reg_write` are 0. `ex_rd` is 0. `Operation` is 4'b0000. Data fields are 0.
- **`valid_in` = 0:** a bubble is loaded.
- **`flush` during `stall`:** flush is ignored. The issuer must hold `flush` until `stall` drops.
- **Forwarding, rs1 and rs2 independently:**
  - EX/MEM is used if `exmem_reg_write`, `exmem_rd` ≠ 0 and `exmem_rd` matches the stored index.
  - Otherwise MEM/WB is used under the same conditions with `memwb_*`.
  - Otherwise the stored register data is used.
  - Index 0 is never forwarded.
- **Operand selection:**
  - `SrcA` is the forwarded rs1, the stored PC, or 0, selected by the stored `a_sel`. The value 3 also selects 0.
  - `SrcB` is the stored immediate if `b_imm` is set, otherwise the forwarded rs2.
  - `store_data` is always the forwarded rs2.
- **Load-use:** `hazard_stall` = `ex_valid` & `ex_mem_read` & `ex_rd` ≠ 0 & (`ex_rd` == `id_rs1_addr` | `ex_rd` == `id_rs2_addr`) & !`stall`. False matches on unused rs2 are accepted (one extra bubble).
- All widths are fixed. There is no arithmetic in this block.

## Timing
- **Reset (`reset` = 0 at edge):** all registers clear to bubble values. After reset, `SrcA` = 0, `SrcB` = 0, `Operation` = 0, `store_data` = 0, `ex_rd` = 0, all control outputs = 0 and `hazard_stall` = 0, provided the forwarding inputs carry no match.
- Reset asserted mid-stall or mid-hazard still clears to a bubble.
- **Latency:** one cycle from ID inputs to registered outputs.
- `SrcA`, `SrcB` and `store_data` are combinational in the same cycle from the forwarding inputs.
- **Load-use:** exactly one bubble per hazard. The next cycle `ex_mem_read` = 0, so `hazard_stall` deasserts. The held ID instruction loads on the following edge and obtains the load value via MEM/WB forwarding.
- **`stall` held N cycles:** outputs stay frozen N cycles. Forwarded operands may still change if the forwarding inputs change.

## Structure
- **Shared package `rv32i_pkg`:**
  - ALU op constants `ALU_AND`=0000, `ALU_OR`=0001, `ALU_ADD`=0010, `ALU_XOR`=0011, `ALU_SUB`=0110, `ALU_EQ`=1000.
  - `a_sel_t` enum (`A_RS1`, `A_PC`, `A_ZERO`).
  - A packed `id_ex_t` struct for the stored fields.
- **Sub-module `operand_forward`:** combinational; takes a stored index and data plus the EX/MEM and MEM/WB triples and returns the forwarded value. It is instantiated twice.

## Test plan
- **Reset:** hold `reset` = 0 with random ID inputs -> next cycle all outputs 0 and `ex_valid` = 0. Release; load ADD with rs1 = 5 / data 7 and rs2 = 6 / data 9 -> `SrcA` = 7, `SrcB` = 9, `Operation` = 0010.
- **Forwarding priority:** stored rs1 = 3; `exmem_rd` = 3 with result 0xAAAA; `memwb_rd` = 3 with result 0xBBBB -> `SrcA` = 0xAAAA. Drop `exmem_reg_write` -> `SrcA` = 0xBBBB.
- **x0 and immediate:** rs1 = 0 with `exmem_rd` = 0 and result 0x55 -> `SrcA` = stored data, not 0x55. `id_b_imm` = 1 with imm 0xFFFFFFFC -> `SrcB` = 0xFFFFFFFC while `store_data` still shows the forwarded rs2.
- **Load-use:** LW to x4, then ADD reading x4 -> `hazard_stall` = 1 for one cycle and a bubble is loaded. Next cycle ADD loads, and with `memwb_rd` = 4 / result 0x1234 -> `SrcA` = 0x1234.
- **Stall vs flush:** load SUB, then `stall` = 1 and `flush` = 1 for 3 cycles -> outputs hold SUB (`Operation` = 0110). Release `stall` with `flush` still 1 -> bubble.
- **Reset mid-hazard:** assert `reset` = 0 on the edge where `hazard_stall` = 1 -> bubble, and `hazard_stall` = 0 next cycle.
